// File: rtl/oam_scan_engine_if.sv
// OAM read bus between the scan engine and the memory it walks.
// The engine holds the address and request; the memory answers with
// data plus a valid strobe that marks the accepting cycle.
interface oam_scan_engine_if;
  logic [15:0] mem_addr_out;
  logic        mem_req_out;
  logic [7:0]  mem_data_in;
  logic        mem_valid_in;

  modport master (
    output mem_addr_out,
    output mem_req_out,
    input  mem_data_in,
    input  mem_valid_in
  );

  modport slave (
    input  mem_addr_out,
    input  mem_req_out,
    output mem_data_in,
    output mem_valid_in
  );
endinterface

// File: rtl/oam_scan_engine.sv
// OAM scan engine for the PPU mode-2 phase.
// Walks every OAM entry (Y byte, then X byte), keeps the sprites that cover the
// latched scanline in ascending OAM order, and exposes them via an indexed port.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start_in; buffer and count hold the last scan
//   REQ_Y | requesting byte 0 (Y) of entry i, waiting for mem_valid_in
//   REQ_X | requesting byte 1 (X) of entry i, admit/overflow on accept
//   DONE  | one-cycle done_out pulse, then back to IDLE
module oam_scan_engine #(
  parameter int          NUM_SPRITES = 40,
  parameter int          BUFFER_MAX  = 10,
  parameter logic [15:0] OAM_BASE    = 16'hFE00,
  parameter int          Y_OFFSET    = 16,
  parameter int          SKIP_X0     = 0,
  localparam int IDX_W   = $clog2(NUM_SPRITES),
  localparam int CNT_W   = $clog2(BUFFER_MAX + 1),
  localparam int RD_W    = (BUFFER_MAX > 1) ? $clog2(BUFFER_MAX) : 1,
  localparam int ENTRY_W = 8 + IDX_W + 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [7:0]         ly_in,
  input  logic               tall_in,
  oam_scan_engine_if.master  mem,
  output logic               busy_out,
  output logic               done_out,
  output logic [CNT_W-1:0]   count_out,
  output logic               overflow_out,
  input  logic [RD_W-1:0]    rd_idx_in,
  output logic [ENTRY_W-1:0] rd_entry_out
);

  typedef enum logic [1:0] {IDLE, REQ_Y, REQ_X, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         ly_q, ly_d;
  logic               tall_q, tall_d;
  logic               hit_q, hit_d;
  logic [3:0]         row_q, row_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [15:0]        addr_q, addr_d;
  logic [ENTRY_W-1:0] buf_q [BUFFER_MAX];
  logic [ENTRY_W-1:0] buf_d [BUFFER_MAX];

  // Hit test runs in 9 bits so Y near 0xFF plus the sprite height never wraps.
  logic [8:0] line9, y9, top9;
  logic       hit_w;
  logic [3:0] row_w;
  logic       skip_x;

  assign line9  = {1'b0, ly_q} + 9'(Y_OFFSET);
  assign y9     = {1'b0, mem.mem_data_in};
  assign top9   = y9 + (tall_q ? 9'd16 : 9'd8);
  assign hit_w  = (y9 <= line9) && (line9 < top9);
  assign row_w  = line9[3:0] - y9[3:0];
  assign skip_x = (SKIP_X0 != 0) && (mem.mem_data_in == 8'd0);

  // Next-state and registered-output computation for the scan sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ly_d    = ly_q;
    tall_d  = tall_q;
    hit_d   = hit_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    buf_d   = buf_q;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d = REQ_Y;
          idx_d   = '0;
          ly_d    = ly_in;
          tall_d  = tall_in;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      REQ_Y: begin
        if (mem.mem_valid_in) begin
          hit_d   = hit_w;
          row_d   = row_w;
          state_d = REQ_X;
        end
      end
      REQ_X: begin
        if (mem.mem_valid_in) begin
          if (hit_q && !skip_x) begin
            if (cnt_q < CNT_W'(BUFFER_MAX)) begin
              buf_d[cnt_q] = {mem.mem_data_in, idx_q, row_q};
              cnt_d        = cnt_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (idx_q == IDX_W'(NUM_SPRITES - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = REQ_Y;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_d  = (state_d == REQ_Y) || (state_d == REQ_X);
    busy_d = req_d;
    done_d = (state_d == DONE);
    addr_d = req_d ? (OAM_BASE + 16'({idx_d, 2'b00}) + {15'd0, state_d == REQ_X}) : 16'd0;
  end

  // State, scan context, buffer and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ly_q    <= '0;
      tall_q  <= 1'b0;
      hit_q   <= 1'b0;
      row_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      for (int k = 0; k < BUFFER_MAX; k++) buf_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ly_q    <= ly_d;
      tall_q  <= tall_d;
      hit_q   <= hit_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
    end
  end

  assign mem.mem_req_out  = req_q;
  assign mem.mem_addr_out = addr_q;
  assign busy_out         = busy_q;
  assign done_out         = done_q;
  assign count_out        = cnt_q;
  assign overflow_out     = ovf_q;
  // Slots at or beyond the current count read as zero, so a fresh scan hides stale entries.
  assign rd_entry_out     = (CNT_W'(rd_idx_in) < cnt_q) ? buf_q[rd_idx_in] : '0;

endmodule

// File: tb/tb_oam_scan_engine.sv
// Bench for oam_scan_engine: two instances (x=0 admitted / x=0 skipped) share
// one stimulus stream and are compared against a behavioural scan model.
module tb_oam_scan_engine;
  localparam int N  = 40;
  localparam int BM = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       tall = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] ly = 8'd0;
  logic [3:0] rd_idx = 4'd0;

  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [3:0]  cnt0, cnt1;
  logic [17:0] ent0, ent1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  oam_y [N];
  logic [7:0]  oam_x [N];
  int          exp_cnt [2];
  logic        exp_ovf [2];
  logic [17:0] exp_ent [2][BM];

  always #5 clk = ~clk;

  oam_scan_engine_if if0();
  oam_scan_engine_if if1();

  assign if0.mem_valid_in = valid;
  assign if1.mem_valid_in = valid;

  oam_scan_engine #(.SKIP_X0(0)) dut0 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .ly_in(ly), .tall_in(tall),
    .mem(if0.master), .busy_out(busy0), .done_out(done0), .count_out(cnt0),
    .overflow_out(ovf0), .rd_idx_in(rd_idx), .rd_entry_out(ent0));

  oam_scan_engine #(.SKIP_X0(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .ly_in(ly), .tall_in(tall),
    .mem(if1.master), .busy_out(busy1), .done_out(done1), .count_out(cnt1),
    .overflow_out(ovf1), .rd_idx_in(rd_idx), .rd_entry_out(ent1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    int idx;
    idx = (int'(a) - 32'hFE00) >> 2;
    if (idx < 0 || idx >= N) return 8'h00;
    return a[0] ? oam_x[idx] : oam_y[idx];
  endfunction

  task automatic refresh_data();
    if0.mem_data_in = mem_rd(if0.mem_addr_out);
    if1.mem_data_in = mem_rd(if1.mem_addr_out);
  endtask

  // Scan rules evaluated directly on the OAM image with integer arithmetic.
  function automatic void model_all(input int l, input bit t);
    for (int s = 0; s < 2; s++) begin
      int cnt = 0;
      bit ovf = 0;
      for (int i = 0; i < N; i++) begin
        int line = l + 16;
        int h = t ? 16 : 8;
        int y = int'(oam_y[i]);
        int x = int'(oam_x[i]);
        if (y <= line && line < y + h && !(s == 1 && x == 0)) begin
          if (cnt < BM) begin
            exp_ent[s][cnt] = {oam_x[i], 6'(i), 4'(line - y)};
            cnt++;
          end else begin
            ovf = 1;
          end
        end
      end
      exp_cnt[s] = cnt;
      exp_ovf[s] = ovf;
    end
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < N; i++) begin
      oam_y[i] = 8'd0;
      oam_x[i] = 8'($urandom_range(1, 255));
    end
  endtask

  task automatic check_buffers(input string tag);
    check({tag, "_cnt0"}, 32'(cnt0), 32'(exp_cnt[0]));
    check({tag, "_cnt1"}, 32'(cnt1), 32'(exp_cnt[1]));
    check({tag, "_ovf0"}, 32'(ovf0), 32'(exp_ovf[0]));
    check({tag, "_ovf1"}, 32'(ovf1), 32'(exp_ovf[1]));
    for (int j = 0; j < 16; j++) begin
      logic [17:0] e0, e1;
      rd_idx = 4'(j);
      #1;
      e0 = 18'd0;
      e1 = 18'd0;
      if (j < exp_cnt[0]) e0 = exp_ent[0][j];
      if (j < exp_cnt[1]) e1 = exp_ent[1][j];
      check($sformatf("%s_ent0[%0d]", tag, j), 32'(ent0), 32'(e0));
      check($sformatf("%s_ent1[%0d]", tag, j), 32'(ent1), 32'(e1));
    end
    rd_idx = 4'd0;
  endtask

  // One full scan; rst_at >= 0 pulls reset once that many bytes have been accepted.
  task automatic run_scan(input string tag, input logic [7:0] l, input logic t,
                          input bit waits, input int rst_at);
    int acc = 0;
    int cyc = 0;
    model_all(int'(l), t);
    @(negedge clk);
    ly = l;
    tall = t;
    start = 1'b1;
    valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    refresh_data();
    check({tag, "_busy_start"}, 32'(busy0), 32'd1);
    check({tag, "_req_start"}, 32'(if0.mem_req_out), 32'd1);
    while (acc < 2 * N && cyc < 3000) begin
      logic [15:0] exp_addr;
      exp_addr = 16'hFE00 + 16'(4 * (acc / 2)) + 16'(acc % 2);
      check({tag, "_addr0"}, 32'(if0.mem_addr_out), 32'(exp_addr));
      check({tag, "_addr1"}, 32'(if1.mem_addr_out), 32'(exp_addr));
      check({tag, "_busy"}, 32'(busy0), 32'd1);
      check({tag, "_early_done"}, 32'(done0), 32'd0);
      if (rst_at >= 0 && acc == rst_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_req"}, 32'(if0.mem_req_out), 32'd0);
        check({tag, "_rst_addr"}, 32'(if0.mem_addr_out), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy0), 32'd0);
        check({tag, "_rst_cnt"}, 32'(cnt0), 32'd0);
        check({tag, "_rst_ovf"}, 32'(ovf0), 32'd0);
        check({tag, "_rst_ent"}, 32'(ent0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk);
          #1;
          check({tag, "_post_rst_done"}, 32'(done0), 32'd0);
          check({tag, "_post_rst_req"}, 32'(if0.mem_req_out), 32'd0);
          check({tag, "_post_rst_cnt"}, 32'(cnt0), 32'd0);
        end
        return;
      end
      valid = waits ? 1'($urandom_range(0, 1)) : 1'b1;
      if (waits && acc == 30) begin
        start = 1'b1;
        ly = ~l;
      end
      @(posedge clk);
      if (valid) acc++;
      cyc++;
      #1;
      start = 1'b0;
      refresh_data();
    end
    if (acc < 2 * N) check({tag, "_timeout"}, 32'(acc), 32'(2 * N));
    valid = 1'b0;
    check({tag, "_done0"}, 32'(done0), 32'd1);
    check({tag, "_done1"}, 32'(done1), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy0), 32'd0);
    check({tag, "_req_at_done"}, 32'(if0.mem_req_out), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(done0), 32'd0);
    check_buffers(tag);
  endtask

  initial begin
    if0.mem_data_in = 8'd0;
    if1.mem_data_in = 8'd0;
    clear_oam();

    // Reset held with toggling inputs.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      ly = 8'($urandom);
      tall = 1'($urandom_range(0, 1));
      valid = 1'($urandom_range(0, 1));
      #1;
      check("reset_req", 32'(if0.mem_req_out), 32'd0);
      check("reset_addr", 32'(if0.mem_addr_out), 32'd0);
      check("reset_busy", 32'(busy0), 32'd0);
      check("reset_done", 32'(done0), 32'd0);
      check("reset_cnt", 32'(cnt0), 32'd0);
      check("reset_ovf", 32'(ovf0), 32'd0);
      check("reset_ent", 32'(ent0), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
    rst_n = 1'b1;

    // Basic 8x8 zero-wait scan.
    clear_oam();
    oam_y[3] = 8'd16; oam_x[3] = 8'd20;
    oam_y[7] = 8'd9;  oam_x[7] = 8'd50;
    run_scan("basic", 8'd0, 1'b0, 1'b0, -1);
    check("basic_count", 32'(cnt0), 32'd2);
    rd_idx = 4'd0; #1;
    check("basic_e0", 32'(ent0), 32'({8'd20, 6'd3, 4'd0}));
    rd_idx = 4'd1; #1;
    check("basic_e1", 32'(ent0), 32'({8'd50, 6'd7, 4'd7}));
    rd_idx = 4'd0;

    // Tall sprites: row 12 in 8x16, no hit in 8x8.
    clear_oam();
    oam_y[5] = 8'd14;
    run_scan("tall16", 8'd10, 1'b1, 1'b0, -1);
    rd_idx = 4'd0; #1;
    check("tall16_row", 32'(ent0[3:0]), 32'd12);
    run_scan("tall8", 8'd10, 1'b0, 1'b0, -1);
    check("tall8_count", 32'(cnt0), 32'd0);

    // Overflow: twelve matches on ly=50.
    clear_oam();
    for (int i = 0; i < 12; i++) oam_y[i * 3] = 8'(66 - (i % 8));
    run_scan("ovf", 8'd50, 1'b0, 1'b0, -1);
    check("ovf_count", 32'(cnt0), 32'd10);
    check("ovf_flag", 32'(ovf0), 32'd1);
    rd_idx = 4'd9; #1;
    check("ovf_idx9", 32'(ent0[9:4]), 32'd27);
    rd_idx = 4'd0;

    // X==0 policy.
    clear_oam();
    oam_y[11] = 8'd20;
    oam_x[11] = 8'd0;
    run_scan("x0", 8'd4, 1'b0, 1'b0, -1);
    check("x0_keep", 32'(cnt0), 32'd1);
    check("x0_skip", 32'(cnt1), 32'd0);

    // Random OAM images, zero-wait and then with wait states.
    for (int r = 0; r < 3; r++) begin
      logic [7:0] rl;
      logic       rt;
      rl = 8'($urandom_range(0, 255));
      rt = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) == 0) oam_y[i] = 8'($urandom);
        else oam_y[i] = 8'(int'(rl) + 16 - int'($urandom_range(0, 17)));
        oam_x[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      end
      run_scan($sformatf("rand%0d_nowait", r), rl, rt, 1'b0, -1);
      run_scan($sformatf("rand%0d_wait", r), rl, rt, 1'b1, -1);
    end

    // Reset in the middle of a scan, at entry 20.
    clear_oam();
    for (int i = 0; i < 12; i++) oam_y[i * 3] = 8'(66 - (i % 8));
    run_scan("midrst", 8'd50, 1'b0, 1'b1, 40);

    // The engine must scan normally after the mid-scan reset.
    clear_oam();
    oam_y[3] = 8'd16; oam_x[3] = 8'd20;
    oam_y[7] = 8'd9;  oam_x[7] = 8'd50;
    run_scan("after_rst", 8'd0, 1'b0, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
